// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit handshake and result bus.
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    modport master (output start, op, a, b, input hi, lo, busy, done, div0);
    modport slave  (input start, op, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (restoring) unit.
// Fixed latency: 32 iteration cycles plus one finalise cycle; divide-by-zero skips RUN.
module mult_div_unit (
    input  logic            clk_i,
    input  logic            rst_ni,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        op_q;
    logic [32:0] acc_q;     // Booth partial product (high) / partial remainder
    logic [32:0] m_q;       // sign-extended multiplicand / divisor magnitude
    logic [31:0] mq_q;      // multiplier (low) / dividend-then-quotient
    logic        q1_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q, div0_q;

    logic [32:0] acc_d;
    logic [31:0] mq_d;
    logic        q1_d;
    logic [32:0] booth_sum;
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi, res_lo;
    logic [31:0] abs_a, abs_b;

    assign abs_a = bus.a[31] ? -bus.a : bus.a;
    assign abs_b = bus.b[31] ? -bus.b : bus.b;

    always_comb begin
        acc_d     = acc_q;
        mq_d      = mq_q;
        q1_d      = q1_q;
        booth_sum = acc_q;
        rem_shift = {acc_q[31:0], mq_q[31]};
        trial     = {1'b0, rem_shift} - {1'b0, m_q};
        case ({mq_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
        if (!op_q) begin
            acc_d = {booth_sum[32], booth_sum[32:1]};
            mq_d  = {booth_sum[0], mq_q[31:1]};
            q1_d  = mq_q[0];
        end else if (!trial[33]) begin
            acc_d = trial[32:0];
            mq_d  = {mq_q[30:0], 1'b1};
        end else begin
            acc_d = rem_shift;
            mq_d  = {mq_q[30:0], 1'b0};
        end
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        quo_fix = neg_quo_q ? -mq_q : mq_q;
        rem_fix = neg_rem_q ? -acc_q[31:0] : acc_q[31:0];
        res_hi  = op_q ? rem_fix : acc_q[31:0];
        res_lo  = op_q ? quo_fix : mq_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            acc_q     <= '0;
            m_q       <= '0;
            mq_q      <= '0;
            q1_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q     <= '0;
                        op_q      <= bus.op;
                        acc_q     <= '0;
                        q1_q      <= 1'b0;
                        neg_quo_q <= bus.a[31] ^ bus.b[31];
                        neg_rem_q <= bus.a[31];
                        busy_q    <= 1'b1;
                        if (bus.op) begin
                            m_q  <= {1'b0, abs_b};
                            mq_q <= abs_a;
                        end else begin
                            m_q  <= {bus.a[31], bus.a};
                            mq_q <= bus.b;
                        end
                        if (bus.op && (bus.b == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            div0_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            div0_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == 6'd32) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                        q1_q  <= q1_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: expected results queued at acceptance, checked on done.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    logic [31:0] mhi, mlo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint p, q, r;
        e.acc = 0;
        if (!o) begin
            p = longint'($signed(x)) * longint'($signed(y));
            e.hi = p[63:32]; e.lo = p[31:0]; e.d0 = 1'b0; e.lat = 33;
        end else if (y == 32'd0) begin
            e.hi = mhi; e.lo = mlo; e.d0 = 1'b1; e.lat = 0;
        end else begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            e.hi = r[31:0]; e.lo = q[31:0]; e.d0 = 1'b0; e.lat = 33;
        end
        return e;
    endfunction

    task automatic push_exp(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e     = model(o, x, y);
        e.acc = cyc;
        mhi   = e.hi;
        mlo   = e.lo;
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the following negedge.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        push_exp(o, x, y);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) ok = 1'b1;
        end
        check("idle_timeout", {63'd0, ok}, 64'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'd0, bus.done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                check("div0", {63'd0, bus.div0}, {63'd0, e.d0});
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    initial begin
        tests = 0; fails = 0; cyc = 0; mhi = '0; mlo = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi",   {32'd0, bus.hi}, 64'd0);
        check("rst_lo",   {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_div0", {63'd0, bus.div0}, 64'd0);

        // Start accepted at the very first edge after release.
        rst_n = 1'b1;
        issue(1'b0, 32'hFFFF_FFFD, 32'd7);
        check("run_busy", {63'd0, bus.busy}, 64'd1);
        check("run_hold_lo", {32'd0, bus.lo}, 64'd0);
        wait_idle();
        check("mul_m3x7_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
        check("mul_m3x7_lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_m7_2_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
        check("div_m7_2_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);

        issue(1'b1, 32'd100, 32'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("div0_hold", {63'd0, bus.div0}, 64'd1);
        check("div0_keep_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);

        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        check("mul_min_hi", {32'd0, bus.hi}, 64'h4000_0000);
        check("div0_cleared", {63'd0, bus.div0}, 64'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("div_wrap_lo", {32'd0, bus.lo}, 64'h8000_0000);
        check("div_wrap_hi", {32'd0, bus.hi}, 64'd0);

        // Start hammered during RUN with new operands: only the first is honoured.
        issue(1'b0, 32'd12345, 32'hFFFF_FF00);
        for (int i = 0; i < 30; i++) begin
            bus.start = 1'b1; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        // Start held through DONE: operands change after acceptance, re-accepted in IDLE.
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_1234;
        @(posedge clk); #1;
        push_exp(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        bus.op = 1'b1; bus.a = 32'h7FFF_FFFF; bus.b = 32'hFFFF_FFF3;
        repeat (35) @(posedge clk);
        #1;
        push_exp(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i == 3) ? 32'd0 : ((i == 5) ? 32'd1 : $urandom);
            issue(1'((i % 2) == 1), x, y);
            wait_idle();
        end

        // Abort mid-RUN with reset.
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        mhi = '0; mlo = '0;
        check("abort_hi",   {32'd0, bus.hi}, 64'd0);
        check("abort_lo",   {32'd0, bus.lo}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", {63'd0, bus.busy}, 64'd0);
        issue(1'b0, 32'd6, 32'd7);
        wait_idle();
        check("mul_6x7_lo", {32'd0, bus.lo}, 64'd42);
        check("mul_6x7_hi", {32'd0, bus.hi}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
